// File: rtl/multiplier_pkg.sv
// Shared state encoding and width helpers for the sequential Q-format multiplier.
package multiplier_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    MUL   = 3'd2,
    STORE = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam int BITSIZE_DEF   = 16;
  localparam int PROD_W        = 2 * BITSIZE_DEF;
  localparam int CYCLES_PER_CH = BITSIZE_DEF + 2;

  // Width-dependent forms for parameterized instances
  function automatic int prod_w(input int bitsize);
    return 2 * bitsize;
  endfunction

  function automatic int cycles_per_ch(input int bitsize);
    return bitsize + 2;
  endfunction

  function automatic int frame_latency(input int bitsize, input int channels);
    return channels * cycles_per_ch(bitsize) + 1;
  endfunction

endpackage

// File: rtl/multiplier_seq_if.sv
// Frame handshake and packed operand/result bus of multiplier_seq.
interface multiplier_seq_if #(
    parameter int BITSIZE  = 16,
    parameter int CHANNELS = 2
);
    logic                         start;
    logic [CHANNELS*BITSIZE-1:0]  in1;
    logic [CHANNELS*BITSIZE-1:0]  in2;
    logic [CHANNELS*BITSIZE-1:0]  out;
    logic                         busy;
    logic                         done;

    modport master (output start, in1, in2, input  out, busy, done);
    modport slave  (input  start, in1, in2, output out, busy, done);
endinterface

// File: rtl/seq_mul_core.sv
// One-channel signed radix-2 shift-add multiplier: load once, then one step per cycle.
module seq_mul_core
    import multiplier_pkg::*;
#(
    parameter int BITSIZE = 16,
    parameter int PW      = prod_w(BITSIZE)
) (
    input  logic                      bclk,
    input  logic                      reset,
    input  logic                      load,
    input  logic                      step,
    input  logic                      last,
    input  logic signed [BITSIZE-1:0] a,
    input  logic signed [BITSIZE-1:0] b,
    output logic signed [PW-1:0]      prod
);

    logic signed [PW-1:0]  mcand_q;
    logic signed [PW-1:0]  acc_q;
    logic [BITSIZE-1:0]    mplier_q;

    // The multiplier's MSB carries weight -2^(BITSIZE-1), so the last step subtracts
    always_ff @(posedge bclk) begin
        if (reset) begin
            mcand_q  <= '0;
            acc_q    <= '0;
            mplier_q <= '0;
        end else if (load) begin
            mcand_q  <= {{(PW-BITSIZE){a[BITSIZE-1]}}, a};
            acc_q    <= '0;
            mplier_q <= b;
        end else if (step) begin
            if (mplier_q[0])
                acc_q <= last ? acc_q - mcand_q : acc_q + mcand_q;
            mcand_q  <= mcand_q <<< 1;
            mplier_q <= mplier_q >> 1;
        end
    end

    assign prod = acc_q;

endmodule

// File: rtl/multiplier_seq.sv
// Frame-sequential multiplier: CHANNELS products through one shared shift-add core.
// Optional build macro MULTIPLIER_SATURATE_EN clamps results instead of wrapping.
module multiplier_seq
    import multiplier_pkg::*;
#(
    parameter int BITSIZE  = 16,
    parameter int CHANNELS = 2,
    parameter int SHIFT    = BITSIZE - 1
) (
    input  logic             bclk,
    input  logic             reset,
    multiplier_seq_if.slave  bus
);

    localparam int PW = prod_w(BITSIZE);
    localparam int IW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int CW = $clog2(BITSIZE + 1);

    typedef logic [CHANNELS-1:0][BITSIZE-1:0] lanes_t;

    state_t  state_q, state_d;
    logic [IW-1:0] idx_q;
    logic [CW-1:0] cnt_q;
    lanes_t  op1_q, op2_q, shadow_q, shadow_d, out_q;

    logic busy, done;
    logic last_ch, last_step;
    logic signed [PW-1:0]      prod, shifted;
    logic        [BITSIZE-1:0] res;

    assign last_ch   = (idx_q == IW'(CHANNELS - 1));
    assign last_step = (cnt_q == CW'(BITSIZE - 1));

    always_ff @(posedge bclk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        unique case (state_q)
            IDLE:  if (bus.start) state_d = LOAD;
            LOAD:  begin busy = 1'b1; state_d = MUL; end
            MUL:   begin busy = 1'b1; if (last_step) state_d = STORE; end
            STORE: begin busy = 1'b1; state_d = last_ch ? DONE : LOAD; end
            DONE:  begin done = 1'b1; state_d = IDLE; end
            default: state_d = IDLE;
        endcase
    end

    seq_mul_core #(.BITSIZE(BITSIZE), .PW(PW)) u_core (
        .bclk  (bclk),
        .reset (reset),
        .load  (state_q == LOAD),
        .step  (state_q == MUL),
        .last  (last_step),
        .a     (op1_q[idx_q]),
        .b     (op2_q[idx_q]),
        .prod  (prod)
    );

    assign shifted = prod >>> SHIFT;

`ifdef MULTIPLIER_SATURATE_EN
    localparam logic signed [PW-1:0] SAT_MAX = {{(PW-BITSIZE+1){1'b0}}, {(BITSIZE-1){1'b1}}};
    localparam logic signed [PW-1:0] SAT_MIN = ~SAT_MAX;

    always_comb begin
        if (shifted > SAT_MAX)      res = SAT_MAX[BITSIZE-1:0];
        else if (shifted < SAT_MIN) res = SAT_MIN[BITSIZE-1:0];
        else                        res = BITSIZE'(shifted);
    end
`else
    assign res = BITSIZE'(shifted);
`endif

    always_comb begin
        shadow_d        = shadow_q;
        shadow_d[idx_q] = res;
    end

    // out is loaded on entry to DONE so it becomes visible together with the done pulse
    always_ff @(posedge bclk) begin
        if (reset) begin
            idx_q    <= '0;
            cnt_q    <= '0;
            op1_q    <= '0;
            op2_q    <= '0;
            shadow_q <= '0;
            out_q    <= '0;
        end else begin
            unique case (state_q)
                IDLE: if (bus.start) begin
                    op1_q <= bus.in1;
                    op2_q <= bus.in2;
                    idx_q <= '0;
                end
                LOAD: cnt_q <= '0;
                MUL:  cnt_q <= cnt_q + CW'(1);
                STORE: begin
                    shadow_q <= shadow_d;
                    if (last_ch) out_q <= shadow_d;
                    else         idx_q <= idx_q + IW'(1);
                end
                default: ;
            endcase
        end
    end

    assign bus.out  = out_q;
    assign bus.busy = busy;
    assign bus.done = done;

endmodule

// File: tb/tb_multiplier_seq.sv
// Randomized and directed bench for multiplier_seq against a frame-level arithmetic model.
module tb_multiplier_seq;

  localparam int B   = 16;
  localparam int C   = 2;
  localparam int SH  = B - 1;
  localparam int LAT = C * (B + 2) + 1;

  logic bclk;
  logic reset;
  int   ncmp = 0;
  int   nerr = 0;
  bit   chk_en = 0;

  multiplier_seq_if #(.BITSIZE(B), .CHANNELS(C)) bus ();

  multiplier_seq #(.BITSIZE(B), .CHANNELS(C), .SHIFT(SH)) dut (
    .bclk  (bclk),
    .reset (reset),
    .bus   (bus)
  );

  initial bclk = 1'b0;
  always #5 bclk = ~bclk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [B-1:0] ref_ch(input logic [B-1:0] a, input logic [B-1:0] b);
    longint p;
    p = longint'($signed(a)) * longint'($signed(b));
    p = p >>> SH;
`ifdef MULTIPLIER_SATURATE_EN
    if (p > 32767)       p = 32767;
    else if (p < -32768) p = -32768;
`endif
    return B'(p);
  endfunction

  function automatic logic [C*B-1:0] ref_frame(input logic [C*B-1:0] a, input logic [C*B-1:0] b);
    logic [C*B-1:0] r;
    r = '0;
    for (int k = 0; k < C; k++) r[k*B +: B] = ref_ch(a[k*B +: B], b[k*B +: B]);
    return r;
  endfunction

  // Frame model: t counts periods since the accepted start; done in period LAT
  int             m_t = 0;
  logic [C*B-1:0] m_exp = '0;
  logic [C*B-1:0] m_out = '0;

  always @(posedge bclk) begin
    if (reset) begin
      m_t   <= 0;
      m_out <= '0;
    end else if (m_t == 0) begin
      if (bus.start === 1'b1) begin
        m_t   <= 1;
        m_exp <= ref_frame(bus.in1, bus.in2);
      end
    end else if (m_t == LAT) begin
      m_t <= 0;
    end else begin
      m_t <= m_t + 1;
      if (m_t + 1 == LAT) m_out <= m_exp;
    end
  end

  always @(negedge bclk) begin
    if (chk_en) begin
      chk("busy", 64'(bus.busy), 64'(m_t >= 1 && m_t < LAT));
      chk("done", 64'(bus.done), 64'(m_t == LAT));
      chk("out",  64'(bus.out),  64'(m_out));
    end
  end

  task automatic run_frame(output int n);
    bus.start = 1'b1;
    @(negedge bclk);
    bus.start = 1'b0;
    n = 1;
    while (bus.done !== 1'b1 && n < 100) begin
      @(negedge bclk);
      n++;
    end
  endtask

  int n, first, dones;
  logic [C*B-1:0] got;

  initial begin
    reset = 1'b1;
    bus.start = 1'b0;
    bus.in1 = '0;
    bus.in2 = '0;
    repeat (3) @(negedge bclk);
    reset = 1'b0;
    chk_en = 1;
    chk("reset_out",  64'(bus.out),  64'h0);
    chk("reset_busy", 64'(bus.busy), 64'h0);
    chk("reset_done", 64'(bus.done), 64'h0);

    // Q15 basics
    bus.in1 = {16'h2000, 16'h4000};
    bus.in2 = {16'h7FFF, 16'h4000};
    run_frame(n);
    chk("lat_basic", 64'(n), 64'(37));
    chk("out_basic", 64'(bus.out), 64'h1FFF2000);
    @(negedge bclk);
    chk("out_hold", 64'(bus.out), 64'h1FFF2000);

    // Most-negative squared
    bus.in1 = {16'h0000, 16'h8000};
    bus.in2 = {16'h1234, 16'h8000};
    run_frame(n);
    chk("lat_minsq", 64'(n), 64'(37));
`ifdef MULTIPLIER_SATURATE_EN
    chk("out_minsq", 64'(bus.out), 64'h00007FFF);
`else
    chk("out_minsq", 64'(bus.out), 64'h00008000);
`endif
    @(negedge bclk);

    // Floor on negatives
    bus.in1 = {16'd12345, 16'hFFFF};
    bus.in2 = {16'hA460,  16'h0001};
    run_frame(n);
    chk("out_floor", 64'(bus.out), 64'hDD7BFFFF);
    @(negedge bclk);

    // Input change and re-start during a frame must not disturb it
    bus.in1 = {16'h2000, 16'h4000};
    bus.in2 = {16'h7FFF, 16'h4000};
    bus.start = 1'b1;
    @(negedge bclk);
    bus.start = 1'b0;
    first = 0; dones = 0; got = '0;
    for (int c = 1; c <= 47; c++) begin
      if (bus.done === 1'b1) begin
        dones++;
        if (first == 0) begin first = c; got = bus.out; end
      end
      if (c == 5) bus.in1 = $urandom();
      bus.start = (c == 10);
      @(negedge bclk);
    end
    chk("restart_lat",   64'(first), 64'(37));
    chk("restart_dones", 64'(dones), 64'(1));
    chk("restart_out",   64'(got),   64'h1FFF2000);

    // Reset in the middle of a frame
    bus.in1 = {16'h2000, 16'h4000};
    bus.in2 = {16'h7FFF, 16'h4000};
    bus.start = 1'b1;
    @(negedge bclk);
    bus.start = 1'b0;
    for (int c = 1; c < 20; c++) @(negedge bclk);
    reset = 1'b1;
    @(negedge bclk);
    reset = 1'b0;
    chk("midrst_busy", 64'(bus.busy), 64'h0);
    chk("midrst_out",  64'(bus.out),  64'h0);
    chk("midrst_done", 64'(bus.done), 64'h0);
    repeat (2) @(negedge bclk);
    run_frame(n);
    chk("midrst_lat", 64'(n), 64'(37));
    chk("midrst_res", 64'(bus.out), 64'h1FFF2000);
    @(negedge bclk);

    // Random frames with ignored starts and operand churn while busy
    for (int f = 0; f < 30; f++) begin
      bus.in1 = $urandom();
      bus.in2 = $urandom();
      if (f % 7 == 3) bus.in1[15:0] = 16'h8000;
      if (f % 5 == 1) bus.in2[31:16] = 16'h7FFF;
      bus.start = 1'b1;
      @(negedge bclk);
      bus.start = 1'b0;
      n = 1;
      while (bus.done !== 1'b1 && n < 100) begin
        if ($urandom_range(7) == 0) begin
          bus.start = 1'b1;
          bus.in1 = $urandom();
          bus.in2 = $urandom();
        end else begin
          bus.start = 1'b0;
        end
        @(negedge bclk);
        n++;
      end
      chk("rand_lat", 64'(n), 64'(37));
      bus.start = 1'($urandom_range(1));
      @(negedge bclk);
      bus.start = 1'b0;
      repeat ($urandom_range(2)) @(negedge bclk);
    end

    repeat (3) @(negedge bclk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
